// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack imem port
// and holds the fetched word for the control unit until it is consumed.
module fetch_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  pc_src,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    ERROR
  } state_t;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  err_q, err_d;
  logic [31:0]           cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FETCH: begin
        // an ack on the timeout cycle still wins
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ISSUE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (pc_src && (pc_target[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            pc_d    = pc_src ? pc_target : pc_plus4;
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
      end
      ERROR: begin
      end
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an instruction-level
// reference model of the fetch/issue protocol.
module tb_fetch_unit;

  localparam int TO = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  fetch_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESET_PC(RST_PC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .pc_src(pc_src),
    .pc_target(pc_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: address of the pending/held instruction, whether one is held,
  // sticky error, cycles spent waiting on the current request
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_instr = NOP;
  logic        m_held = 1'b0;
  logic        m_err = 1'b0;
  int          m_wait = 0;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic s, input logic ps,
                     input logic [31:0] pt);
    imem_ack   = a;
    imem_rdata = a ? tag(imem_addr) : 32'hBAD0_BAD0;
    stall      = s;
    pc_src     = ps;
    pc_target  = pt;
    if (rst) begin
      #1 check("req_in_rst", {31'b0, imem_req}, 32'd0);
      m_pc = RST_PC; m_instr = NOP; m_held = 1'b0;
      m_err = 1'b0; m_wait = 0;
    end else if (m_err) begin
    end else if (!m_held) begin
      if (a) begin
        m_held = 1'b1; m_instr = tag(m_pc); m_wait = 0;
      end else if (m_wait + 1 == TO) begin
        m_err = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (!s) begin
      m_held = 1'b0;
      if (ps && pt[1:0] != 2'b00) m_err = 1'b1;
      else m_pc = ps ? pt : m_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    check("valid", {31'b0, instr_valid}, {31'b0, m_held});
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("err", {31'b0, fetch_err}, {31'b0, m_err});
    check("req", {31'b0, imem_req},
          {31'b0, !m_held && !m_err && !rst});
    check("addr", imem_addr, m_pc);
    check("instr", instr, m_instr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  logic [31:0] pt;

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, NOP);

    // zero-wait streaming
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    check("stream_pc", pc, 32'h10);

    // ack after 3 wait cycles, then a boundary ack on cycle TO
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    check("late_ack_valid", {31'b0, instr_valid}, 32'd1);

    // stall holds the issued instruction
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 32'h80);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("post_stall_addr", imem_addr, 32'h14);

    // redirect from 0x10, then a misaligned one
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    check("at_10", pc, 32'h10);
    cyc(1'b1, 1'b0, 1'b1, 32'h40);
    check("redir_addr", imem_addr, 32'h40);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 32'h42);
    check("misalign_err", {31'b0, fetch_err}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);

    // timeout without ack
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    check("timeout_err", {31'b0, fetch_err}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, '0);

    // reset during the 2nd wait cycle at 0x8, with a stale ack
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, '0);
    rst = 1'b0;
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0) ||
            (m_err && $urandom_range(0, 7) == 0);
      pt = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 19) == 0) pt[1:0] = 2'($urandom_range(1, 3));
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, pt);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of control_unit and the datapath.
- Owns the PC register and fetches instructions from a variable-latency instruction memory via a req/ack handshake.
- Presents `instr`, `pc` and `pc_plus4` with a valid flag, and holds them under stall.
- Applies the `pc_src`/`pc_target` redirect returned by the control unit and branch adder.

Parameters:
DATA_WIDTH, 32, instruction width and imem data width
ADDR_WIDTH, 32, PC and imem address width
RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned
TIMEOUT_CYCLES, 255, max FETCH cycles without ack before error; 0 disables timeout

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  downstream not accepting the current instruction
pc_src  input  1  1: next PC = pc_target; 0: next PC = pc+4; sampled only on consume
pc_target  input  ADDR_WIDTH  branch/jump target from datapath
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_WIDTH  fetch address; equals pc
imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  input  DATA_WIDTH  fetched instruction word
instr  output  DATA_WIDTH  registered instruction to control_unit
instr_valid  output  1  instr/pc/pc_plus4 are valid
pc  output  ADDR_WIDTH  address of current/pending instruction
pc_plus4  output  ADDR_WIDTH  pc + 4, combinational from pc register
fetch_err  output  1  sticky: timeout or misaligned redirect

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (rst=1 at an edge, overriding everything):
  - pc=RESET_PC, instr=32'h00000013 (NOP), instr_valid=0, fetch_err=0.
  - wait counter=0, state=FETCH.
  - imem_req is 0 during any cycle with rst=1.
- States: FETCH, ISSUE, ERROR.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, counter<=0, next state ISSUE.
  - Otherwise counter increments.
  - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without ack: fetch_err<=1, next state ERROR.
- ISSUE:
  - imem_req=0, instr_valid=1.
  - stall=1: instr and pc hold unchanged indefinitely.
  - stall=0: instruction is consumed this cycle. pc <= pc_src ? pc_target : pc+4; instr_valid<=0; next state FETCH.
- Misaligned redirect: pc_src=1 on consume with pc_target[1:0]!=0 sets fetch_err<=1, next state ERROR, pc unchanged.
- ERROR: imem_req=0, instr_valid=0; exits only via rst.
- Latency:
  - Zero-wait memory (ack in the same cycle as req): instr_valid is asserted on the cycle after req.
  - Peak throughput is 1 instruction per 2 cycles; N wait states add N cycles.
- Arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH; no overflow flag.
- Boundaries:
  - stall and pc_src are don't-care outside ISSUE.
  - ack arriving in the same cycle the timeout would fire takes priority: a normal fetch, no error.
  - Reset mid-FETCH abandons the outstanding request: imem_req drops in the reset cycle, and any late ack is ignored until the next req.

Test Plan:
- Reset, then zero-wait memory returning addr-tagged words, stall=0, pc_src=0 -> imem_addr 0,4,8,12 on alternating cycles; instr_valid pulses 1-in-2; instr matches address.
- Ack delayed 3 cycles -> imem_req held high 4 cycles with imem_addr stable; instr_valid rises the cycle after ack; fetch_err=0.
- stall=1 for 5 cycles while instr_valid=1 -> instr, pc and instr_valid constant; first cycle after stall drops, imem_req=1 at pc+4.
- At pc=0x10, consume with pc_src=1, pc_target=0x40 -> next imem_addr=0x40. Repeat with pc_target=0x42 -> fetch_err=1, ERROR state, no further req.
- TIMEOUT_CYCLES=4, ack never given -> fetch_err rises after 4 FETCH cycles, imem_req=0 thereafter. Ack on exactly the 4th cycle -> normal fetch.
- Assert rst during the 2nd wait cycle of a fetch at 0x8 -> next cycle pc=RESET_PC, instr_valid=0, fetch_err=0; a stale ack during reset is ignored.
